// File: rtl/if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pkg
// Shared pipeline definitions for the instruction fetch stage: datapath
// width, instruction size, default reset PC, NOP encoding, the fetch FSM
// state type and small PC helpers.
// ----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int          XLEN         = 32;
    localparam int          INSTR_BYTES  = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Sequential next fetch address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/if_fetch_chk.sv
// ----------------------------------------------------------------------------
// if_fetch_chk
// Simulation-only invariant checker for if_fetch. Holds no state; only
// observes the fetch bookkeeping.
// Ports (all inputs):
//   clk, reset         clock and asynchronous active-high reset
//   i_inflight         requests accepted but not yet answered
//   i_drop             answers still to be discarded
//   i_q_count          output queue occupancy
//   i_pcq_count        in-flight PC FIFO occupancy
//   i_pcq_full/empty   in-flight PC FIFO flags
//   i_accept           request handshake this cycle
//   i_resp_keep        response being kept this cycle
// ----------------------------------------------------------------------------
module if_fetch_chk #(
    parameter int DEPTH = 2
) (
    input logic                       clk,
    input logic                       reset,
    input logic [$clog2(DEPTH+1)-1:0] i_inflight,
    input logic [$clog2(DEPTH+1)-1:0] i_drop,
    input logic [$clog2(DEPTH+1)-1:0] i_q_count,
    input logic [$clog2(DEPTH+1)-1:0] i_pcq_count,
    input logic                       i_pcq_full,
    input logic                       i_pcq_empty,
    input logic                       i_accept,
    input logic                       i_resp_keep
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW:0] w_used;
    assign w_used = {1'b0, i_inflight} + {1'b0, i_q_count};

    a_credit:   assert property (@(posedge clk) disable iff (reset) w_used <= (CW+1)'(DEPTH));
    a_drop:     assert property (@(posedge clk) disable iff (reset) i_drop <= i_inflight);
    a_pcq_live: assert property (@(posedge clk) disable iff (reset) i_pcq_count == (i_inflight - i_drop));
    a_pcq_push: assert property (@(posedge clk) disable iff (reset) !(i_accept && i_pcq_full));
    a_pcq_pop:  assert property (@(posedge clk) disable iff (reset) !(i_resp_keep && i_pcq_empty));

endmodule

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous clear. Head entry is visible
// combinationally on o_dout. Storage is reset so the head reads zero after
// reset.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_push, i_din    write request and data (ignored when full, unless popping)
//   i_pop            read request (ignored when empty)
//   i_clear          drop every entry (wins over push/pop)
//   o_dout           head entry
//   o_count          number of stored entries
//   o_full, o_empty  status flags
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
// Instruction fetch stage feeding the IF/ID register. Owns the fetch PC,
// issues in-order word fetches under a credit limit of DEPTH (in-flight plus
// queued), buffers answers with their PC and hands them to IF/ID. A redirect
// flushes everything and discards answers already in flight.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   redirect, redirect_pc      EX redirect/flush and its target
//   stall                      hazard stall, IF/ID holds
//   imem_req_valid/ready/addr  request channel to instruction memory
//   imem_resp_valid/data       in-order response channel, never backpressured
//   out_instr, out_pc          head instruction and its PC
//   out_valid                  an entry transfers to IF/ID this cycle
// ----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_valid
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic         w_run;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_inflight_next;
    logic [CW-1:0] w_drop_next;
    logic [CW:0]   w_used;
    logic          w_issue;
    logic          w_accept;
    logic          w_resp_drop;
    logic          w_resp_keep;

    logic [31:0]   w_pcq_head;
    logic [CW-1:0] w_pcq_count;
    logic          w_pcq_full;
    logic          w_pcq_empty;
    logic [63:0]   w_q_head;
    logic [CW-1:0] w_q_count;
    logic          w_q_full;
    logic          w_q_empty;
    logic          w_unused_bits;

    // The two low target bits are dropped: fetches are always word aligned.
    assign w_unused_bits = &{1'b0, redirect_pc[1:0], w_q_full};

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a single idle BOOT cycle, then RUN until reset.
    always_comb begin
        w_state_next = ST_BOOT;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_run = 1'b0;
        case (r_state)
            ST_RUN:  w_run = 1'b1;
            default: w_run = 1'b0;
        endcase
    end

    // Credits cover answers still in flight (dropped ones included) plus
    // queued entries, so the output queue can never overflow.
    assign w_used      = {1'b0, r_inflight} + {1'b0, w_q_count};
    assign w_issue     = w_run && !redirect && (w_used < (CW+1)'(DEPTH));
    assign w_accept    = w_issue && imem_req_ready;
    assign w_resp_drop = imem_resp_valid && (r_drop != {CW{1'b0}});
    assign w_resp_keep = imem_resp_valid && (r_drop == {CW{1'b0}}) && !redirect;

    // In-flight and drop bookkeeping; on redirect every answer still owed
    // after this cycle becomes stale.
    always_comb begin
        w_inflight_next = r_inflight + CW'(w_accept) - CW'(imem_resp_valid);
        if (redirect) begin
            w_drop_next = w_inflight_next;
        end else if (w_resp_drop) begin
            w_drop_next = r_drop - CW'(1);
        end else begin
            w_drop_next = r_drop;
        end
    end

    // Fetch PC and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= {CW{1'b0}};
            r_drop     <= {CW{1'b0}};
        end else begin
            r_inflight <= w_inflight_next;
            r_drop     <= w_drop_next;
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_accept) begin
                r_fetch_pc <= pc_plus4(r_fetch_pc);
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
        end
    end

    // PCs of live requests, matched in order to their answers.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_din   (r_fetch_pc),
        .i_pop   (w_resp_keep),
        .i_clear (redirect),
        .o_dout  (w_pcq_head),
        .o_count (w_pcq_count),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty)
    );

    // Output queue of {pc, instr}; no bypass, so an answer shows up the
    // cycle after it arrives.
    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_out_q (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_resp_keep),
        .i_din   ({w_pcq_head, imem_resp_data}),
        .i_pop   (out_valid),
        .i_clear (redirect),
        .o_dout  (w_q_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign imem_req_valid = w_issue;
    assign imem_req_addr  = r_fetch_pc;
    assign out_pc         = w_q_head[63:32];
    assign out_instr      = w_q_head[31:0];
    assign out_valid      = !w_q_empty && !stall && !redirect;

    if_fetch_chk #(.DEPTH(DEPTH)) u_chk (
        .clk         (clk),
        .reset       (reset),
        .i_inflight  (r_inflight),
        .i_drop      (r_drop),
        .i_q_count   (w_q_count),
        .i_pcq_count (w_pcq_count),
        .i_pcq_full  (w_pcq_full),
        .i_pcq_empty (w_pcq_empty),
        .i_accept    (w_accept),
        .i_resp_keep (w_resp_keep)
    );

endmodule
